mem_dump: RTL

Hardware read-out engine for the processor's data/instruction RAM. On a start command it reads a contiguous range of 32-bit words through a synchronous RAM read port. It emits each word as four bytes, least-significant first, on a valid/ready byte stream. It sits beside `proc` on the RAM's spare read port and feeds a byte sink (UART transmitter or bench monitor). It replaces simulation-only `$display` dumps with a synthesizable path.

---
 rtl/miscv_dbg_pkg.sv | 24 ++
 rtl/mem_dump_word_serializer.sv | 53 +++++
 rtl/mem_dump.sv | 111 +++++++++++
 3 files changed

// File: rtl/miscv_dbg_pkg.sv
// rtl/miscv_dbg_pkg.sv - shared types and constants for the RAM dump engine
//
// Contents:
//   dump_state_t    : mem_dump controller states
//   BYTES_PER_WORD  : bytes emitted per RAM word
//   BYTE_W          : width of one stream byte
//   WORD_W          : RAM data width
//   IDX_W           : width of the byte index within a word
package miscv_dbg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT,
        ST_SEND,
        ST_DONE
    } dump_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_W         = 8;
    localparam int WORD_W         = BYTES_PER_WORD * BYTE_W;
    localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/mem_dump_word_serializer.sv
// rtl/mem_dump_word_serializer.sv - splits one 32-bit word into a byte stream, LSB first
//
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture word and start presenting byte 0
//   word       : word to serialize
//   tx_valid   : byte available
//   tx_data    : current byte (low byte of the shift register)
//   tx_ready   : sink accepts byte
//   last_byte  : pulses on the handshake of the final byte of the word
module word_serializer
    import miscv_dbg_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] word,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready,
    output logic              last_byte
);

    logic [WORD_W-1:0] shift_q;
    logic [IDX_W-1:0]  idx_q;
    logic              valid_q;
    logic              fire;

    assign fire      = valid_q && tx_ready;
    assign last_byte = fire && (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign tx_valid  = valid_q;
    // Data only moves on a handshake, so it is stable while stalled.
    assign tx_data   = shift_q[BYTE_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (load) begin
            shift_q <= word;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (fire) begin
            shift_q <= shift_q >> BYTE_W;
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
                valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mem_dump.sv
// rtl/mem_dump.sv - reads a word range from RAM and streams it out as bytes, LSB first
//
// Parameters:
//   ADDR_W : RAM word-address width
//   CNT_W  : word-count width
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   start                : command strobe, honoured only when idle
//   base_addr, word_count: command arguments, captured on accepted start
//   busy, done           : command in progress / one-cycle completion pulse
//   mem_re, mem_addr     : synchronous RAM read request
//   mem_rdata            : RAM data, valid the cycle after mem_re
//   tx_valid, tx_data    : byte stream out
//   tx_ready             : byte stream back-pressure
module mem_dump
    import miscv_dbg_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic              busy,
    output logic              done,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              tx_valid,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_ready
);

    dump_state_t       state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  remain_q;
    logic              accept;
    logic              load;
    logic              last_byte;

    assign accept   = (state_q == ST_IDLE) && start;
    assign mem_addr = addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q   <= base_addr;
                remain_q <= word_count;
            end else if (last_byte) begin
                // Address wraps naturally at 2^ADDR_W.
                addr_q   <= addr_q + ADDR_W'(1);
                remain_q <= remain_q - CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b1;
        done    = 1'b0;
        mem_re  = 1'b0;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = (word_count == CNT_W'(0)) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                mem_re  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                load    = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (last_byte) begin
                    state_d = (remain_q == CNT_W'(1)) ? ST_DONE : ST_READ;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    word_serializer u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .word      (mem_rdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .last_byte (last_byte)
    );

endmodule
